// File: rtl/jk_seq_decoder_if.sv
// Bus between the JK counter monitor and its user: sampled {A,B}, error clear,
// and all decoded status. The decoder takes the slave side.
interface jk_seq_decoder_if #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
);
  logic             sample_en;
  logic             A;
  logic             B;
  logic             clr_err;
  logic             valid;
  logic             E_rec;
  logic             x_rec;
  logic             illegal;
  logic             err_sticky;
  logic             wrap_up;
  logic             wrap_down;
  logic [CNT_W-1:0] step_cnt;
  logic [ERR_W-1:0] err_cnt;
  logic             dir_flip;

  modport master (
    output sample_en, A, B, clr_err,
    input  valid, E_rec, x_rec, illegal, err_sticky, wrap_up, wrap_down,
           step_cnt, err_cnt, dir_flip
  );

  modport slave (
    input  sample_en, A, B, clr_err,
    output valid, E_rec, x_rec, illegal, err_sticky, wrap_up, wrap_down,
           step_cnt, err_cnt, dir_flip
  );
endinterface

// File: rtl/jk_seq_decoder.sv
// Monitor for the 2-bit enable/direction JK counter: recovers E/x per sample,
// flags +2 jumps, counts steps and wraps. JK_DEC_DIR_FLIP_EN adds dir_flip.
module jk_seq_decoder #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  jk_seq_decoder_if.slave   bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       prev_q, prev_d;
  logic             valid_q, valid_d;
  logic             e_q, e_d;
  logic             x_q, x_d;
  logic             ill_q, ill_d;
  logic             sticky_q, sticky_d;
  logic             wup_q, wup_d;
  logic             wdn_q, wdn_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [1:0] cur, d;
  assign cur = {bus.A, bus.B};
  assign d   = cur - prev_q;

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    valid_d  = 1'b0;
    e_d      = e_q;
    x_d      = x_q;
    ill_d    = 1'b0;
    sticky_d = sticky_q;
    wup_d    = 1'b0;
    wdn_d    = 1'b0;
    step_d   = step_q;
    err_d    = err_q;
    // clr_err is treated like every other input: it acts only on a sampled cycle
    if (bus.sample_en) begin
      prev_d = cur;
      if (state_q == S_IDLE) begin
        state_d = S_TRACK;
      end else begin
        valid_d = 1'b1;
        wup_d   = (prev_q == 2'b11) && (cur == 2'b00);
        wdn_d   = (prev_q == 2'b00) && (cur == 2'b11);
        if (bus.clr_err && state_q == S_ERROR) begin
          sticky_d = 1'b0;
          state_d  = S_TRACK;
        end
        unique case (d)
          2'd0: e_d = 1'b0;
          2'd1, 2'd3: begin
            e_d = 1'b1;
            x_d = (d == 2'd1);
            if (state_q == S_TRACK && step_q != {CNT_W{1'b1}})
              step_d = step_q + 1'b1;
          end
          default: begin
            // illegal overrides a simultaneous clr_err
            e_d      = 1'b0;
            ill_d    = 1'b1;
            sticky_d = 1'b1;
            state_d  = S_ERROR;
            if (err_q != {ERR_W{1'b1}})
              err_d = err_q + 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      prev_q   <= 2'b00;
      valid_q  <= 1'b0;
      e_q      <= 1'b0;
      x_q      <= 1'b0;
      ill_q    <= 1'b0;
      sticky_q <= 1'b0;
      wup_q    <= 1'b0;
      wdn_q    <= 1'b0;
      step_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      valid_q  <= valid_d;
      e_q      <= e_d;
      x_q      <= x_d;
      ill_q    <= ill_d;
      sticky_q <= sticky_d;
      wup_q    <= wup_d;
      wdn_q    <= wdn_d;
      step_q   <= step_d;
      err_q    <= err_d;
    end
  end

  assign bus.valid      = valid_q;
  assign bus.E_rec      = e_q;
  assign bus.x_rec      = x_q;
  assign bus.illegal    = ill_q;
  assign bus.err_sticky = sticky_q;
  assign bus.wrap_up    = wup_q;
  assign bus.wrap_down  = wdn_q;
  assign bus.step_cnt   = step_q;
  assign bus.err_cnt    = err_q;

`ifdef JK_DEC_DIR_FLIP_EN
  logic have_dir_q, have_dir_d;
  logic last_dir_q, last_dir_d;
  logic flip_q, flip_d;
  logic step_ev, step_up;

  assign step_ev = bus.sample_en && (state_q != S_IDLE) && d[0];
  assign step_up = (d == 2'd1);

  always_comb begin
    have_dir_d = have_dir_q;
    last_dir_d = last_dir_q;
    flip_d     = 1'b0;
    // an IDLE reference sample starts a fresh direction history
    if (bus.sample_en && state_q == S_IDLE) begin
      have_dir_d = 1'b0;
    end else if (step_ev) begin
      flip_d     = have_dir_q && (last_dir_q != step_up);
      have_dir_d = 1'b1;
      last_dir_d = step_up;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      have_dir_q <= 1'b0;
      last_dir_q <= 1'b0;
      flip_q     <= 1'b0;
    end else begin
      have_dir_q <= have_dir_d;
      last_dir_q <= last_dir_d;
      flip_q     <= flip_d;
    end
  end

  assign bus.dir_flip = flip_q;
`else
  assign bus.dir_flip = 1'b0;
`endif
endmodule

// File: tb/tb_jk_seq_decoder.sv
// Directed bench for jk_seq_decoder: a default instance plus a CNT_W=2 instance
// sharing stimulus for the saturation case.
module tb_jk_seq_decoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

`ifdef JK_DEC_DIR_FLIP_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif

  jk_seq_decoder_if #(.CNT_W(8), .ERR_W(4)) bus ();
  jk_seq_decoder_if #(.CNT_W(2), .ERR_W(4)) sbus ();

  assign sbus.sample_en = bus.sample_en;
  assign sbus.A         = bus.A;
  assign sbus.B         = bus.B;
  assign sbus.clr_err   = bus.clr_err;

  jk_seq_decoder #(.CNT_W(8), .ERR_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  jk_seq_decoder #(.CNT_W(2), .ERR_W(4)) dut_s (.clk(clk), .reset(reset), .bus(sbus));

  always #5 clk = ~clk;

  task automatic smp(input logic [1:0] ab, input logic clr);
    bus.sample_en = 1'b1;
    {bus.A, bus.B} = ab;
    bus.clr_err = clr;
    @(posedge clk);
    #1;
    bus.sample_en = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.sample_en = 1'b1;
    {bus.A, bus.B} = 2'b11;
    bus.clr_err = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.sample_en = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic test_reset();
    smp(2'b00, 1'b0);
    smp(2'b01, 1'b0);
    do_reset();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", bus.valid); end
    checks++; if ({bus.E_rec, bus.x_rec, bus.illegal, bus.err_sticky} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b exp 0000", {bus.E_rec, bus.x_rec, bus.illegal, bus.err_sticky}); end
    checks++; if ({bus.wrap_up, bus.wrap_down, bus.dir_flip} !== 3'b0) begin errors++; $display("FAIL rst_pulses got %b exp 000", {bus.wrap_up, bus.wrap_down, bus.dir_flip}); end
    checks++; if (bus.step_cnt !== 8'd0 || bus.err_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnts got %0d/%0d exp 0/0", bus.step_cnt, bus.err_cnt); end
  endtask

  task automatic test_up();
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b10, 2'b11, 2'b00};
    smp(2'b00, 1'b0);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL up_ref_valid got %0b exp 0", bus.valid); end
    for (int i = 0; i < 4; i++) begin
      smp(seq[i], 1'b0);
      checks++; if ({bus.valid, bus.E_rec, bus.x_rec} !== 3'b111) begin errors++; $display("FAIL up_decode[%0d] got %b exp 111", i, {bus.valid, bus.E_rec, bus.x_rec}); end
      checks++; if (bus.wrap_up !== (i == 3)) begin errors++; $display("FAIL up_wrap[%0d] got %0b exp %0b", i, bus.wrap_up, (i == 3)); end
    end
    checks++; if (bus.step_cnt !== 8'd4) begin errors++; $display("FAIL up_step got %0d exp 4", bus.step_cnt); end
  endtask

  task automatic test_down();
    logic [1:0] seq [4];
    seq = '{2'b11, 2'b10, 2'b01, 2'b00};
    do_reset();
    smp(2'b00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      smp(seq[i], 1'b0);
      checks++; if ({bus.valid, bus.E_rec, bus.x_rec} !== 3'b110) begin errors++; $display("FAIL dn_decode[%0d] got %b exp 110", i, {bus.valid, bus.E_rec, bus.x_rec}); end
      checks++; if (bus.wrap_down !== (i == 0) || bus.wrap_up !== 1'b0) begin errors++; $display("FAIL dn_wrap[%0d] got %0b%0b exp %0b0", i, bus.wrap_down, bus.wrap_up, (i == 0)); end
    end
    checks++; if (bus.step_cnt !== 8'd4) begin errors++; $display("FAIL dn_step got %0d exp 4", bus.step_cnt); end
  endtask

  task automatic test_hold();
    do_reset();
    smp(2'b00, 1'b0);
    smp(2'b01, 1'b0);
    smp(2'b10, 1'b0);
    for (int i = 0; i < 2; i++) begin
      smp(2'b10, 1'b0);
      checks++; if ({bus.valid, bus.E_rec, bus.x_rec, bus.illegal} !== 4'b1010) begin errors++; $display("FAIL hold[%0d] got %b exp 1010", i, {bus.valid, bus.E_rec, bus.x_rec, bus.illegal}); end
      checks++; if (bus.step_cnt !== 8'd2) begin errors++; $display("FAIL hold_step[%0d] got %0d exp 2", i, bus.step_cnt); end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    smp(2'b00, 1'b0);
    smp(2'b10, 1'b0);
    checks++; if ({bus.valid, bus.illegal, bus.E_rec, bus.err_sticky} !== 4'b1101) begin errors++; $display("FAIL ill_flags got %b exp 1101", {bus.valid, bus.illegal, bus.E_rec, bus.err_sticky}); end
    checks++; if (bus.err_cnt !== 4'd1 || bus.step_cnt !== 8'd0) begin errors++; $display("FAIL ill_cnts got %0d/%0d exp 1/0", bus.err_cnt, bus.step_cnt); end
    smp(2'b11, 1'b0);
    checks++; if ({bus.valid, bus.E_rec, bus.x_rec, bus.illegal} !== 4'b1110) begin errors++; $display("FAIL err_decode got %b exp 1110", {bus.valid, bus.E_rec, bus.x_rec, bus.illegal}); end
    checks++; if (bus.step_cnt !== 8'd0) begin errors++; $display("FAIL err_frozen got %0d exp 0", bus.step_cnt); end
    smp(2'b11, 1'b1);
    checks++; if (bus.err_sticky !== 1'b0 || bus.err_cnt !== 4'd1) begin errors++; $display("FAIL clr got %0b/%0d exp 0/1", bus.err_sticky, bus.err_cnt); end
    smp(2'b00, 1'b0);
    checks++; if (bus.step_cnt !== 8'd1 || bus.wrap_up !== 1'b1) begin errors++; $display("FAIL clr_track got %0d/%0b exp 1/1", bus.step_cnt, bus.wrap_up); end
  endtask

  task automatic test_clr_collision();
    smp(2'b10, 1'b1);
    checks++; if ({bus.illegal, bus.err_sticky} !== 2'b11 || bus.err_cnt !== 4'd2) begin errors++; $display("FAIL coll got %b/%0d exp 11/2", {bus.illegal, bus.err_sticky}, bus.err_cnt); end
    smp(2'b11, 1'b0);
    checks++; if (bus.step_cnt !== 8'd1 || bus.err_sticky !== 1'b1) begin errors++; $display("FAIL coll_error got %0d/%0b exp 1/1", bus.step_cnt, bus.err_sticky); end
    smp(2'b00, 1'b1);
    checks++; if (bus.step_cnt !== 8'd1 || bus.err_sticky !== 1'b0 || bus.wrap_up !== 1'b1) begin errors++; $display("FAIL coll_clr got %0d/%0b/%0b exp 1/0/1", bus.step_cnt, bus.err_sticky, bus.wrap_up); end
    smp(2'b01, 1'b1);
    checks++; if (bus.step_cnt !== 8'd2 || bus.err_sticky !== 1'b0) begin errors++; $display("FAIL clr_in_track got %0d/%0b exp 2/0", bus.step_cnt, bus.err_sticky); end
  endtask

  task automatic test_saturate();
    logic [1:0] seq [5];
    seq = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    do_reset();
    smp(2'b00, 1'b0);
    for (int i = 0; i < 5; i++) smp(seq[i], 1'b0);
    checks++; if (sbus.step_cnt !== 2'd3) begin errors++; $display("FAIL step_sat got %0d exp 3", sbus.step_cnt); end
    checks++; if (bus.step_cnt !== 8'd5) begin errors++; $display("FAIL step_wide got %0d exp 5", bus.step_cnt); end
    do_reset();
    smp(2'b00, 1'b0);
    for (int i = 0; i < 16; i++) smp((i % 2 == 0) ? 2'b10 : 2'b00, 1'b0);
    checks++; if (bus.err_cnt !== 4'd15 || bus.illegal !== 1'b1) begin errors++; $display("FAIL err_sat got %0d/%0b exp 15/1", bus.err_cnt, bus.illegal); end
    checks++; if (bus.step_cnt !== 8'd0) begin errors++; $display("FAIL err_sat_step got %0d exp 0", bus.step_cnt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    checks++; if (bus.err_cnt !== 4'd0 || bus.err_sticky !== 1'b0 || bus.valid !== 1'b0) begin errors++; $display("FAIL mid_rst got %0d/%0b/%0b exp 0/0/0", bus.err_cnt, bus.err_sticky, bus.valid); end
    smp(2'b01, 1'b0);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL mid_ref_valid got %0b exp 0", bus.valid); end
    {bus.A, bus.B} = 2'b11;
    @(posedge clk);
    #1;
    checks++; if (bus.valid !== 1'b0 || bus.step_cnt !== 8'd0) begin errors++; $display("FAIL idle_cycle got %0b/%0d exp 0/0", bus.valid, bus.step_cnt); end
    smp(2'b10, 1'b0);
    checks++; if ({bus.valid, bus.E_rec, bus.x_rec} !== 3'b111 || bus.step_cnt !== 8'd1) begin errors++; $display("FAIL mid_step got %b/%0d exp 111/1", {bus.valid, bus.E_rec, bus.x_rec}, bus.step_cnt); end
  endtask

  task automatic test_dir_flip();
    do_reset();
    smp(2'b00, 1'b0);
    smp(2'b01, 1'b0);
    checks++; if (bus.dir_flip !== 1'b0) begin errors++; $display("FAIL flip_first got %0b exp 0", bus.dir_flip); end
    smp(2'b00, 1'b0);
    checks++; if (bus.dir_flip !== FLIP) begin errors++; $display("FAIL flip_rev got %0b exp %0b", bus.dir_flip, FLIP); end
    smp(2'b00, 1'b0);
    checks++; if (bus.dir_flip !== 1'b0) begin errors++; $display("FAIL flip_hold got %0b exp 0", bus.dir_flip); end
    smp(2'b11, 1'b0);
    checks++; if (bus.dir_flip !== 1'b0) begin errors++; $display("FAIL flip_same got %0b exp 0", bus.dir_flip); end
    smp(2'b00, 1'b0);
    checks++; if (bus.dir_flip !== FLIP) begin errors++; $display("FAIL flip_rev2 got %0b exp %0b", bus.dir_flip, FLIP); end
  endtask

  initial begin
    bus.sample_en = 1'b0;
    bus.A = 1'b0;
    bus.B = 1'b0;
    bus.clr_err = 1'b0;
    do_reset();
    test_reset();
    test_up();
    test_down();
    test_hold();
    test_illegal();
    test_clr_collision();
    test_saturate();
    test_mid_reset();
    test_dir_flip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jk_seq_decoder.md
Name: jk_seq_decoder

Overview:
- Observer and decoder for the 2-bit enable/direction JK counter.
- Samples the counter's {A,B} outputs and recovers the enable (E) and direction (x) that produced each transition.
- Flags illegal jumps, counts valid steps and reports mod-4 wrap events.
- Sits beside the counter as its reader/monitor, for self-check and status reporting.

Parameters:
- CNT_W, 8, width of the valid-step counter step_cnt.
- ERR_W, 4, width of the illegal-transition counter err_cnt.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- sample_en  input  1  when 1, {A,B} is sampled this cycle
- A  input  1  counter MSB
- B  input  1  counter LSB
- clr_err  input  1  clears err_sticky and leaves the ERROR state
- valid  output  1  one-cycle pulse: decoded fields are fresh
- E_rec  output  1  recovered enable for the last decoded sample
- x_rec  output  1  recovered direction (1 = up, 0 = down)
- illegal  output  1  one-cycle pulse: a +2 jump was detected
- err_sticky  output  1  set on illegal, held until clr_err
- wrap_up  output  1  one-cycle pulse on the 11->00 up step
- wrap_down  output  1  one-cycle pulse on the 00->11 down step
- step_cnt  output  CNT_W  count of valid up/down steps, saturating
- err_cnt  output  ERR_W  count of illegal jumps, saturating
- dir_flip  output  1  see Optional Feature

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - FSM goes to IDLE; prev_state = 00.
  - All outputs go to 0, including step_cnt and err_cnt.
  - Reset overrides every other input in the same cycle.
- States:
  - IDLE: no reference sample yet.
  - TRACK: normal decoding.
  - ERROR: illegal jump seen, counting frozen.
- sample_en = 0: no state or register changes; all pulse outputs are 0.
- IDLE, sample_en = 1:
  - prev_state <= {A,B}; FSM goes to TRACK.
  - No valid pulse (no difference can be computed yet).
- TRACK/ERROR, sample_en = 1:
  - d = ({A,B} - prev_state) mod 4; prev_state <= {A,B}.
  - All outputs are registered and appear the cycle after the sample (latency 1).
  - valid pulses 1 for every sample, including holds and illegals.
- Decode of d:
  - d = 0 (hold): E_rec = 0; x_rec keeps its previous value.
  - d = 1 (up): E_rec = 1, x_rec = 1.
  - d = 3 (down): E_rec = 1, x_rec = 0.
  - d = 2 (illegal): illegal pulses, E_rec = 0, x_rec holds, err_sticky <= 1, err_cnt += 1 (saturates at 2^ERR_W - 1), FSM goes to ERROR.
- step_cnt:
  - Increments on d = 1 or d = 3, in TRACK only.
  - Saturates at 2^CNT_W - 1; never wraps.
  - Frozen in ERROR.
- Wrap pulses:
  - wrap_up when prev = 11 and cur = 00.
  - wrap_down when prev = 00 and cur = 11.
  - Generated in TRACK and ERROR.
- ERROR:
  - Decoding, valid and prev_state continue to update.
  - clr_err = 1 clears err_sticky and moves the FSM to TRACK; err_cnt is not cleared.
- Simultaneous events:
  - clr_err and an illegal sample in the same cycle: illegal wins; stays in (or enters) ERROR with err_sticky = 1.
  - clr_err while in TRACK or IDLE: no effect.
- Reset mid-stream: returns to IDLE; the next sample becomes the new reference with no valid pulse.

Optional Feature:
- Macro: JK_DEC_DIR_FLIP_EN.
- Defined:
  - dir_flip pulses 1 (same cycle as valid) when a decoded up/down step has a direction opposite to the last decoded up/down step.
  - Holds and illegals neither trigger it nor update the stored last direction.
  - The first step after reset or IDLE never flips.
- Undefined: dir_flip is tied to 0 and no direction-history register is built.

Test Plan:
1. Reset, then sample 00, 01, 10, 11, 00 -> no valid on the first sample; four valid pulses with E_rec = 1, x_rec = 1; wrap_up on the last; step_cnt = 4.
2. Sample 00, 11, 10, 01, 00 -> E_rec = 1, x_rec = 0 on each; wrap_down on the first step; step_cnt = 4.
3. Sample 10, 10, 10 -> two valid pulses with E_rec = 0; x_rec unchanged; step_cnt unchanged.
4. Sample 00 then 10 -> illegal = 1, err_cnt = 1, err_sticky = 1; the following 10->11 step gives valid = 1 but step_cnt stays frozen; clr_err -> back in TRACK, err_sticky = 0, err_cnt = 1.
5. Illegal sample with clr_err in the same cycle -> err_sticky = 1 and FSM in ERROR; CNT_W = 2 with five up steps -> step_cnt saturates at 3.
6. Reset asserted mid-sequence with sample_en held -> all outputs 0 next cycle; first post-reset sample gives no valid; with JK_DEC_DIR_FLIP_EN, sequence 00, 01, 00 -> dir_flip pulses on the second step only.
